// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// controller state encoding and operation select constants.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_seq_cond_neg.sv
// Conditional two's-complement negation, shared by the operand magnitude
// stage and the result sign-fix stage of muldiv_seq.
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] data_i,
    input  logic         neg_i,
    output logic [W-1:0] data_o
);

    assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on operand magnitudes, sign fixed at the end.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             signed_mode,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   aOp_q,     aOp_d;
    logic [WIDTH-1:0]   bOp_q,     bOp_d;
    logic               op_q,      op_d;
    logic               sgn_q,     sgn_d;
    logic               negRes_q,  negRes_d;
    logic               negRem_q,  negRem_d;
    logic [WIDTH-1:0]   accHi_q,   accHi_d;
    logic [WIDTH-1:0]   accLo_q,   accLo_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               divZero_q, divZero_d;

    logic [WIDTH-1:0]   absA, absB, remOut;
    logic [2*WIDTH-1:0] fixIn, fixOut;
    logic [WIDTH:0]     mulSum, divShift, divDiff;

    cond_neg #(.W(WIDTH)) uNegA (
        .data_i (aOp_q),
        .neg_i  (sgn_q & aOp_q[WIDTH-1]),
        .data_o (absA)
    );

    cond_neg #(.W(WIDTH)) uNegB (
        .data_i (bOp_q),
        .neg_i  (sgn_q & bOp_q[WIDTH-1]),
        .data_o (absB)
    );

    // Quotient negation reuses the wide negator: the low half of a 2W-bit
    // negation of {0, q} is exactly the W-bit negation of q.
    assign fixIn = (op_q == OP_MUL) ? {accHi_q, accLo_q} : {{WIDTH{1'b0}}, accLo_q};

    cond_neg #(.W(2 * WIDTH)) uNegRes (
        .data_i (fixIn),
        .neg_i  (negRes_q),
        .data_o (fixOut)
    );

    cond_neg #(.W(WIDTH)) uNegRem (
        .data_i (accHi_q),
        .neg_i  (negRem_q),
        .data_o (remOut)
    );

    assign mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, bOp_q} : '0);
    assign divShift = {accHi_q, accLo_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, bOp_q};

    always_comb begin
        state_d   = state_q;
        aOp_d     = aOp_q;
        bOp_d     = bOp_q;
        op_d      = op_q;
        sgn_d     = sgn_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divZero_d = divZero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PREP;
                    aOp_d     = a;
                    bOp_d     = b;
                    op_d      = op;
                    sgn_d     = SIGNED_EN && signed_mode;
                    divZero_d = 1'b0;
                end
            end
            ST_PREP: begin
                negRes_d = sgn_q & (aOp_q[WIDTH-1] ^ bOp_q[WIDTH-1]);
                negRem_d = sgn_q & aOp_q[WIDTH-1];
                accHi_d  = '0;
                accLo_d  = absA;
                bOp_d    = absB;
                cnt_d    = '0;
                if (op_q == OP_DIV && bOp_q == '0) begin
                    divZero_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    {accHi_d, accLo_d} = {mulSum, accLo_q[WIDTH-1:1]};
                end else if (!divDiff[WIDTH]) begin
                    accHi_d = divDiff[WIDTH-1:0];
                    accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
                end else begin
                    accHi_d = divShift[WIDTH-1:0];
                    accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (op_q == OP_MUL) begin
                    {hi_d, lo_d} = fixOut;
                end else begin
                    hi_d = remOut;
                    lo_d = fixOut[WIDTH-1:0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abort leaves every visible result exactly as it was.
        if (flush && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            divZero_d = divZero_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            aOp_q     <= '0;
            bOp_q     <= '0;
            op_q      <= 1'b0;
            sgn_q     <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aOp_q     <= aOp_d;
            bOp_q     <= bOp_d;
            op_q      <= op_d;
            sgn_q     <= sgn_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divZero_q <= divZero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign div_zero = divZero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the stimulus side pushes results from a
// plain-arithmetic reference model, a monitor pops and compares on each done.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start, op, signedMode, flush;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         busy, done, divZero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           doneCnt;
        string        tag;
    } expEntry;

    expEntry      sbQ[$];
    int           cycleCnt = 0;
    int           numChecks = 0;
    int           numFails = 0;
    logic [W-1:0] modelHi = '0;
    logic [W-1:0] modelLo = '0;
    logic         modelDz = 1'b0;

    muldiv_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .reset       (rstN),
        .start       (start),
        .op          (op),
        .signed_mode (signedMode),
        .flush       (flush),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_zero    (divZero)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected result straight from integer arithmetic on the operands.
    function automatic expEntry refModel(input logic opIn, input logic sgnIn,
                                         input logic [W-1:0] aIn, input logic [W-1:0] bIn);
        expEntry e;
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p64;
        sa = longint'($signed(aIn));
        sb = longint'($signed(bIn));
        ua = 64'(aIn);
        ub = 64'(bIn);
        e.doneCnt = 0;
        e.tag = "";
        if (opIn && bIn == '0) begin
            e.hi = modelHi;
            e.lo = modelLo;
            e.dz = 1'b1;
        end else if (!opIn) begin
            p64  = sgnIn ? 64'(sa * sb) : 64'(ua * ub);
            e.hi = p64[63:32];
            e.lo = p64[31:0];
            e.dz = 1'b0;
        end else begin
            if (sgnIn) begin
                sq = sa / sb;
                sr = sa % sb;
                e.lo = sq[31:0];
                e.hi = sr[31:0];
            end else begin
                uq = ua / ub;
                ur = ua % ub;
                e.lo = uq[31:0];
                e.hi = ur[31:0];
            end
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idleTimeout", 64'(busy), 64'd0);
    endtask

    // Called on a negedge; the start is taken at the following posedge.
    task automatic issueOp(input logic opIn, input logic sgnIn, input logic [W-1:0] aIn,
                           input logic [W-1:0] bIn, input string tag, input bit push);
        expEntry e;
        int startCnt;
        op         = opIn;
        signedMode = sgnIn;
        a          = aIn;
        b          = bIn;
        start      = 1'b1;
        startCnt   = cycleCnt + 1;
        if (push) begin
            e = refModel(opIn, sgnIn, aIn, bIn);
            e.tag = tag;
            e.doneCnt = (opIn && bIn == '0) ? startCnt + 1 : startCnt + W + 2;
            modelHi = e.hi;
            modelLo = e.lo;
            modelDz = e.dz;
            sbQ.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        checkOutput({tag, "_dzClr"}, 64'(divZero), 64'd0);
        if (push == 1'b0) modelDz = 1'b0;
    endtask

    task automatic applyStimulus(input logic opIn, input logic sgnIn, input logic [W-1:0] aIn,
                                 input logic [W-1:0] bIn, input string tag);
        waitIdle();
        issueOp(opIn, sgnIn, aIn, bIn, tag, 1'b1);
    endtask

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        expEntry e;
        forever begin
            @(negedge clk);
            if (rstN && done) begin
                if (sbQ.size() == 0) begin
                    numChecks++;
                    numFails++;
                    $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, expected no pulse", cycleCnt);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                    checkOutput({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
                    checkOutput({e.tag, "_dz"}, 64'(divZero), 64'(e.dz));
                    checkOutput({e.tag, "_latency"}, 64'(cycleCnt), 64'(e.doneCnt));
                end
            end
        end
    end

    initial begin
        int n;
        rstN       = 1'b0;
        start      = 1'b0;
        op         = 1'b0;
        signedMode = 1'b0;
        flush      = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_dz", 64'(divZero), 64'd0);
        rstN = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umulMax");
        applyStimulus(1'b0, 1'b1, -32'sd7, 32'sd6, "smulNeg");
        applyStimulus(1'b1, 1'b1, -32'sd7, 32'sd2, "sdivNeg");
        applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdivWrap");
        applyStimulus(1'b1, 1'b0, 32'h0000_2211, 32'h0000_0100, "udivPrep");
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, "divZero");
        applyStimulus(1'b0, 1'b0, 32'd3, 32'd4, "afterDz");

        // A second start while busy must be ignored entirely.
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, "busyIgn");
        repeat (5) @(negedge clk);
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Flush mid-RUN: no done pulse, results untouched.
        waitIdle();
        issueOp(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003, "flushOp", 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_hi", 64'(hi), 64'(modelHi));
        checkOutput("flush_lo", 64'(lo), 64'(modelLo));
        checkOutput("flush_dz", 64'(divZero), 64'(modelDz));

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                          pickOperand(), pickOperand(), $sformatf("rnd%0d", i));
        end

        // Reset mid-RUN, then a start on the first edge after release.
        applyStimulus(1'b0, 1'b0, 32'h0000_0101, 32'h0000_0202, "preRst");
        waitIdle();
        issueOp(1'b1, 1'b0, 32'h7777_7777, 32'h0000_0013, "rstOp", 1'b0);
        repeat (12) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midRst_hi", 64'(hi), 64'd0);
        checkOutput("midRst_lo", 64'(lo), 64'd0);
        checkOutput("midRst_busy", 64'(busy), 64'd0);
        checkOutput("midRst_done", 64'(done), 64'd0);
        checkOutput("midRst_dz", 64'(divZero), 64'd0);
        modelHi = '0;
        modelLo = '0;
        modelDz = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        issueOp(1'b1, 1'b1, -32'sd100, 32'sd7, "postRst", 1'b1);

        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput("sbDrain", 64'(sbQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand width, even, 8..64.
REQ-002 Parameter SIGNED_EN, default 1: 1 enables signed mode; 0 forces unsigned regardless of signed_mode.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 op  in  1  0 = multiply, 1 = divide.
REQ-007 signed_mode  in  1  1 = two's-complement operands.
REQ-008 flush  in  1  synchronous abort of the current operation.
REQ-009 a  in  WIDTH  multiplicand / dividend.
REQ-010 b  in  WIDTH  multiplier / divisor.
REQ-011 hi  out  WIDTH  product upper half / remainder.
REQ-012 lo  out  WIDTH  product lower half / quotient.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a result or error is reported.
REQ-015 div_zero  out  1  sticky divide-by-zero flag.

Function
REQ-016 States are IDLE, PREP, RUN, FIX and DONE; the unit SHALL have no other states.
REQ-017 IDLE to PREP when start=1; a, b, op and signed_mode are latched at that edge.
REQ-018 PREP (1 cycle) takes absolute values of the latched operands when signed, records the result signs, and clears the iteration counter.
REQ-019 PREP goes to DONE if op=1 and b=0: div_zero is set to 1, and hi/lo keep their previous values.
REQ-020 RUN lasts exactly WIDTH cycles and performs one step per cycle: a shift-add step for multiply, or a restoring shift-subtract step for divide.
REQ-021 FIX (1 cycle) negates results as needed and loads hi/lo.
  - Multiply: the full product is negated when the operand signs differ.
  - Divide: the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-022 DONE (1 cycle) asserts done=1 and then returns to IDLE.
REQ-023 Latency: done is high in the cycle ending at edge k+WIDTH+3, where k is the edge at which start was sampled. A divide by zero asserts done at edge k+2.
REQ-024 hi/lo change only in FIX and hold their value otherwise.
REQ-025 div_zero clears at the edge that accepts the next start.
REQ-026 Multiply result is the exact 2*WIDTH-bit product: {hi,lo}.
REQ-027 Divide truncates toward zero.
REQ-028 Signed divide of most-negative by -1 gives lo = most-negative (wrap) and hi = 0, with no error flag.
REQ-029 Unsigned operation treats the operands as 0..2^WIDTH-1.
REQ-030 start while busy=1 SHALL be ignored and have no side effect.
REQ-031 flush=1 in any non-IDLE state returns the unit to IDLE at the next edge.
  - No done pulse is produced.
  - hi, lo and div_zero are unchanged.
  - flush has priority over every other transition.
REQ-032 start and flush high together in IDLE: start wins and the operation begins.

Reset
REQ-033 reset low SHALL immediately force: state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, latched operands=0.
REQ-034 Reset mid-operation discards the operation with no done pulse.
REQ-035 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-036 A shared package muldiv_pkg SHALL hold:
  - the state enumeration;
  - the op encoding constants OP_MUL and OP_DIV.
REQ-037 One sub-module, cond_neg, SHALL be parametrised by width and perform conditional two's-complement negation. It is used in PREP and FIX.
REQ-038 The iteration counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-039 WIDTH=32, unsigned multiply a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 35 cycles after start.
REQ-040 Signed multiply a=-7, b=6 -> {hi,lo}=-42, i.e. hi=0xFFFFFFFF, lo=0xFFFFFFD6.
REQ-041 Signed divide:
  - a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-042 Divide a=5, b=0 with prior hi/lo=0x11/0x22 -> done 2 cycles after start, div_zero=1, hi/lo unchanged. The next start clears div_zero.
REQ-043 Flush and reset:
  - flush at RUN cycle 10 -> no done pulse, busy low next cycle, hi/lo unchanged.
  - reset low mid-RUN -> all outputs 0 immediately.
REQ-044 start pulsed during busy -> ignored; the result equals that of the first operation and only one done pulse is produced.
